// File: rtl/fasm_fifo_lvl.sv
// Synchronous FWFT FIFO with binary wrap-bit pointers, occupancy count and almost-full/empty flags.
// Optional sticky overflow/underflow flags are built when FASM_FIFO_ERR_EN is defined.
module fasm_fifo_lvl #(
    parameter int AW  = 4,
    parameter int DW  = 32,
    parameter int AFT = 2**AW - 2,
    parameter int AET = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          ena_i,
    input  logic [DW-1:0] dat_i,
    input  logic          wre_i,
    input  logic          rde_i,
    output logic [DW-1:0] dat_o,
    output logic          rok_o,
    output logic          wok_o,
    output logic [AW:0]   lvl_o,
    output logic          afu_o,
    output logic          aem_o,
    output logic          ovf_o,
    output logic          unf_o
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wadr;
    logic [AW:0]   r_radr;
    logic [AW:0]   r_lvl;
    logic [AW:0]   w_lvl_nxt;
    logic          r_rok;
    logic          r_wok;
    logic          r_afu;
    logic          r_aem;
    logic          w_flush;
    logic          w_wre;
    logic          w_rde;

    function automatic logic f_rok(input logic [AW:0] lvl);
        return (int'(lvl) != 0);
    endfunction

    function automatic logic f_wok(input logic [AW:0] lvl);
        return (int'(lvl) != DEPTH);
    endfunction

    function automatic logic f_afu(input logic [AW:0] lvl);
        return (int'(lvl) >= AFT);
    endfunction

    function automatic logic f_aem(input logic [AW:0] lvl);
        return (int'(lvl) <= AET);
    endfunction

    if (AW > 8 || AW < 1) begin : g_warn_aw
        $warning("fasm_fifo_lvl: AW=%0d outside supported range 1..8", AW);
    end
    if (AFT > DEPTH || AET >= DEPTH) begin : g_warn_thr
        $warning("fasm_fifo_lvl: thresholds AFT=%0d AET=%0d out of range for depth %0d",
                 AFT, AET, DEPTH);
    end

    // Flush wins over every strobe, so a flush cycle never touches memory either.
    assign w_flush = rst_i | clr_i;
    assign w_wre   = ena_i & wre_i & r_wok & ~w_flush;
    assign w_rde   = ena_i & rde_i & r_rok & ~w_flush;

    always_comb begin
        w_lvl_nxt = r_lvl;
        case ({w_wre, w_rde})
            2'b10:   w_lvl_nxt = r_lvl + (AW+1)'(1);
            2'b01:   w_lvl_nxt = r_lvl - (AW+1)'(1);
            default: w_lvl_nxt = r_lvl;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_wadr <= '0;
            r_radr <= '0;
            r_lvl  <= '0;
            r_rok  <= 1'b0;
            r_wok  <= 1'b1;
            r_afu  <= (AFT == 0);
            r_aem  <= 1'b1;
        end else if (ena_i) begin
            if (w_wre) begin
                r_wadr <= r_wadr + (AW+1)'(1);
            end
            if (w_rde) begin
                r_radr <= r_radr + (AW+1)'(1);
            end
            r_lvl <= w_lvl_nxt;
            r_rok <= f_rok(w_lvl_nxt);
            r_wok <= f_wok(w_lvl_nxt);
            r_afu <= f_afu(w_lvl_nxt);
            r_aem <= f_aem(w_lvl_nxt);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wre) begin
            r_mem[r_wadr[AW-1:0]] <= dat_i;
        end
    end

    // Head of queue is read combinationally so a new word is visible right after its write edge.
    assign dat_o = r_mem[r_radr[AW-1:0]];
    assign rok_o = r_rok;
    assign wok_o = r_wok;
    assign lvl_o = r_lvl;
    assign afu_o = r_afu;
    assign aem_o = r_aem;

`ifdef FASM_FIFO_ERR_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (ena_i & wre_i & ~r_wok);
            r_unf <= r_unf | (ena_i & rde_i & ~r_rok);
        end
    end

    assign ovf_o = r_ovf;
    assign unf_o = r_unf;
`else
    assign ovf_o = 1'b0;
    assign unf_o = 1'b0;
`endif

endmodule
